// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch button-control slice.
// The clock frequency here also sets the top level's divider parameters.
package stopwatch_pkg;

    localparam int unsigned SYS_CLK_HZ       = 50_000_000;
    localparam int unsigned DEB_CNT_DEFAULT  = SYS_CLK_HZ / 100;  // 10 ms
    localparam int unsigned LONG_CNT_DEFAULT = SYS_CLK_HZ;        // 1 s

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } lap_state_t;

endpackage

// File: rtl/stopwatch_btn_ctrl_if.sv
// Button inputs and clean control outputs of the stopwatch control stage.
// The board side (master) drives the buttons; the control block (slave) drives the controls.
interface stopwatch_btn_ctrl_if;

    logic btn_ss;
    logic btn_lap;
    logic run;
    logic ss_pulse;
    logic clr;
    logic lap_hold;

    modport master (
        output btn_ss, btn_lap,
        input  run, ss_pulse, clr, lap_hold
    );

    modport slave (
        input  btn_ss, btn_lap,
        output run, ss_pulse, clr, lap_hold
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser and consecutive-sample debounce for one raw button.
// Emits the accepted level together with one-cycle rise/fall pulses.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEB_CNT = DEB_CNT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEB_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

    logic [1:0]    sync_reg;
    logic          stable_reg;
    logic          rise_reg;
    logic          fall_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg   <= '0;
            stable_reg <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync_reg <= {sync_reg[0], raw};
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            if (sync_reg[1] == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                // Edge pulses are registered alongside the level so both appear together.
                stable_reg <= sync_reg[1];
                rise_reg   <= sync_reg[1];
                fall_reg   <= !sync_reg[1];
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign stable = stable_reg;
    assign rise   = rise_reg;
    assign fall   = fall_reg;

endmodule

// File: rtl/stopwatch_btn_ctrl.sv
// Stopwatch control: debounced start/stop toggles run; lap button drives lap-hold and long-press clear.
// Define STOPWATCH_LAP_EN for lap-hold behaviour; without it only the long-press clear remains.
module stopwatch_btn_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEB_CNT  = DEB_CNT_DEFAULT,
    parameter int unsigned LONG_CNT = LONG_CNT_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    stopwatch_btn_ctrl_if.slave bus
);

    localparam int HW = $clog2(LONG_CNT + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CNT - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CNT);

    // Index 0 is start/stop, index 1 is lap/clear.
    logic [1:0] raw;
    logic [1:0] stable;
    logic [1:0] rise;
    logic [1:0] fall;

    assign raw = {bus.btn_lap, bus.btn_ss};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            btn_debounce #(
                .DEB_CNT(DEB_CNT)
            ) u_deb (
                .clk   (clk),
                .rst   (rst),
                .raw   (raw[gi]),
                .stable(stable[gi]),
                .rise  (rise[gi]),
                .fall  (fall[gi])
            );
        end
    endgenerate

    // Levels and the start/stop release are intentionally not used by the control logic.
    logic unused_levels;
    assign unused_levels = ^{stable, fall[0]};

    lap_state_t    state_reg;
    logic [HW-1:0] hold_cnt_reg;
    logic          run_reg;
    logic          ss_pulse_reg;
    logic          clr_reg;
`ifdef STOPWATCH_LAP_EN
    logic          lap_hold_reg;
`endif

    // Lap decisions read run_reg before this cycle's toggle takes effect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
            run_reg      <= 1'b0;
            ss_pulse_reg <= 1'b0;
            clr_reg      <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_hold_reg <= 1'b0;
`endif
        end else begin
            ss_pulse_reg <= 1'b0;
            clr_reg      <= 1'b0;
            if (rise[0]) begin
                run_reg      <= !run_reg;
                ss_pulse_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (rise[1]) begin
                        state_reg    <= PRESS;
                        hold_cnt_reg <= '0;
                    end
                end
                PRESS: begin
                    if (fall[1]) begin
                        state_reg <= IDLE;
`ifdef STOPWATCH_LAP_EN
                        if (run_reg) begin
                            lap_hold_reg <= !lap_hold_reg;
                        end else begin
                            lap_hold_reg <= 1'b0;
                        end
`endif
                    end else if (hold_cnt_reg == HOLD_LAST) begin
                        state_reg    <= LONG;
                        hold_cnt_reg <= HOLD_MAX;
                        if (!run_reg) begin
                            clr_reg <= 1'b1;
`ifdef STOPWATCH_LAP_EN
                            lap_hold_reg <= 1'b0;
`endif
                        end
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + HW'(1);
                    end
                end
                LONG: begin
                    if (fall[1]) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.run      = run_reg;
    assign bus.ss_pulse = ss_pulse_reg;
    assign bus.clr      = clr_reg;
`ifdef STOPWATCH_LAP_EN
    assign bus.lap_hold = lap_hold_reg;
`else
    assign bus.lap_hold = 1'b0;
`endif

endmodule
